// File: rtl/conv_result_drain.sv
// conv_result_drain: captures NPU conv write-back vectors into a small FIFO and
// drains them byte-serially, MSB byte first, over a valid/ready host port.
module conv_result_drain #(
  parameter int LENGTH = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      conv_write,
  input  logic [ADDR_W-1:0]         conv_addr,
  input  logic [LENGTH*8-1:0]       conv_v,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_data,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [$clog2(LENGTH)-1:0] out_idx,
  output logic                      out_last,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      overflow,
  input  logic                      clear_ovf
);

  localparam int IDX_W = $clog2(LENGTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LENGTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]          state;
  logic [0:0]          state_next;
  logic [IDX_W-1:0]    idx;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic [LENGTH*8-1:0] vec_mem  [DEPTH];
  logic [ADDR_W-1:0]   addr_mem [DEPTH];
  logic [LENGTH*8-1:0] head_vec;
  logic [IDX_W-1:0]    sel;
  logic                xfer;
  logic                pop;
  logic                push;

  // A full FIFO still accepts a vector when its head retires in the same cycle.
  assign full = (cnt == DEPTH_CNT);
  assign xfer = (state == SEND) && out_ready;
  assign pop  = xfer && (idx == LAST_IDX);
  assign push = conv_write && (!full || pop);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    cnt_next   = cnt;
    state_next = state;
    case ({push, pop})
      2'b10:   cnt_next = cnt + CNT_W'(1);
      2'b01:   cnt_next = cnt - CNT_W'(1);
      default: cnt_next = cnt;
    endcase
    case (state)
      IDLE:    state_next = (cnt_next != '0) ? SEND : IDLE;
      SEND:    state_next = (pop && cnt_next == '0) ? IDLE : SEND;
      default: state_next = IDLE;
    endcase
  end

  // Byte i of the vector sits at bit offset 8*(LENGTH-1-i).
  assign sel       = LAST_IDX - idx;
  assign head_vec  = vec_mem[rd_ptr];
  assign out_valid = (state == SEND);
  assign out_data  = out_valid ? head_vec[{sel, 3'b000} +: 8] : 8'h00;
  assign out_addr  = out_valid ? addr_mem[rd_ptr] : '0;
  assign out_idx   = idx;
  assign out_last  = out_valid && (idx == LAST_IDX);
  assign count     = cnt;

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (xfer) idx    <= pop ? '0 : idx + IDX_W'(1);
      if (conv_write && !push) overflow <= 1'b1;
      else if (clear_ovf)      overflow <= 1'b0;
    end
  end

  // NOTE: the storage array is deliberately not reset; the port gates it with out_valid so stale contents never escape.
  always_ff @(posedge clk) begin
    if (push) begin
      vec_mem[wr_ptr]  <= conv_v;
      addr_mem[wr_ptr] <= conv_addr;
    end
  end

endmodule

// File: tb/tb_conv_result_drain.sv
// Randomized scoreboard bench for conv_result_drain: a queue-level model predicts
// acceptance and the byte stream; a separate monitor compares every transferred byte.
module tb_conv_result_drain;

  localparam int LENGTH = 16;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int IDX_W  = $clog2(LENGTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef struct {
    logic [ADDR_W-1:0]   addr;
    logic [LENGTH*8-1:0] data;
  } vec_t;

  typedef struct {
    logic [7:0]        data;
    logic [ADDR_W-1:0] addr;
    int                idx;
    logic              last;
  } beat_t;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                conv_write = 1'b0;
  logic [ADDR_W-1:0]   conv_addr = '0;
  logic [LENGTH*8-1:0] conv_v = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [7:0]          out_data;
  logic [ADDR_W-1:0]   out_addr;
  logic [IDX_W-1:0]    out_idx;
  logic                out_last;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic                overflow;
  logic                clear_ovf = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model state: vectors held, bytes already sent from the head, sticky overflow.
  vec_t  mq[$];
  beat_t expq[$];
  int    mpos = 0;
  bit    movf = 1'b0;
  int    m_sz;
  bit    m_xfer, m_pop, m_acc;
  vec_t  m_vec;
  beat_t m_beat;

  beat_t mon_exp;
  beat_t held;
  bit    stall = 1'b0;

  conv_result_drain #(.LENGTH(LENGTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .conv_write (conv_write),
    .conv_addr  (conv_addr),
    .conv_v     (conv_v),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .count      (count),
    .full       (full),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: compares the current cycle's status, then applies the coming edge's events.
  always @(negedge clk) begin
    if (!reset) begin
      mq.delete();
      expq.delete();
      mpos = 0;
      movf = 1'b0;
    end else begin
      m_sz = mq.size();
      check("out_valid", out_valid, m_sz != 0);
      check("count", count, m_sz);
      check("full", full, m_sz == DEPTH);
      check("overflow", overflow, movf);
      m_xfer = (m_sz != 0) && out_ready;
      m_pop  = m_xfer && (mpos == LENGTH - 1);
      if (m_xfer) mpos = m_pop ? 0 : mpos + 1;
      m_acc = conv_write && ((m_sz < DEPTH) || m_pop);
      if (m_pop) m_vec = mq.pop_front();
      if (m_acc) begin
        m_vec.addr = conv_addr;
        m_vec.data = conv_v;
        mq.push_back(m_vec);
        for (int i = 0; i < LENGTH; i++) begin
          m_beat.data = conv_v[8*(LENGTH-1-i) +: 8];
          m_beat.addr = conv_addr;
          m_beat.idx  = i;
          m_beat.last = (i == LENGTH - 1);
          expq.push_back(m_beat);
        end
      end
      if (conv_write && !m_acc) movf = 1'b1;
      else if (clear_ovf)       movf = 1'b0;
    end
  end

  // Monitor: every handshake pops one expected byte; stalled outputs must hold.
  always @(negedge clk) begin
    if (!reset) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, held.data);
        check("hold_addr", out_addr, held.addr);
        check("hold_idx", out_idx, held.idx);
        check("hold_last", out_last, held.last);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data %0h idx %0d expected no transfer", out_data, out_idx);
        end else begin
          mon_exp = expq.pop_front();
          check("out_data", out_data, mon_exp.data);
          check("out_addr", out_addr, mon_exp.addr);
          check("out_idx", out_idx, mon_exp.idx);
          check("out_last", out_last, mon_exp.last);
        end
      end
      stall = out_valid && !out_ready;
      held.data = out_data;
      held.addr = out_addr;
      held.idx  = out_idx;
      held.last = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LENGTH*8-1:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_vec(input logic [ADDR_W-1:0] a, input logic [LENGTH*8-1:0] d);
    conv_write = 1'b1;
    conv_addr  = a;
    conv_v     = d;
    tick();
    conv_write = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (mq.size() == 0 && expq.size() == 0) return;
      tick();
    end
    total++;
    bad++;
    $display("FAIL %s: got %0d bytes pending after %0d cycles expected 0", name, expq.size(), limit);
  endtask

  task automatic wait_for_last(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (out_last) begin
        seen = 1'b1;
        return;
      end
      tick();
    end
    total++;
    bad++;
    $display("FAIL wait_last: got no out_last within %0d cycles expected one", limit);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_data"}, out_data, 8'h00);
    check({tag, "_addr"}, out_addr, '0);
    check({tag, "_idx"}, out_idx, '0);
    check({tag, "_last"}, out_last, 1'b0);
    check({tag, "_count"}, count, '0);
    check({tag, "_full"}, full, 1'b0);
    check({tag, "_ovf"}, overflow, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bit reached;

    #12;
    check_reset_outputs("reset");
    tick();
    reset = 1'b1;
    tick();

    // 1: single ascending vector, host always ready.
    out_ready = 1'b1;
    push_vec(5'd3, 128'h000102030405060708090A0B0C0D0E0F);
    wait_drain("t1_drain", 40);

    // 2: host ready toggling every cycle.
    push_vec(5'd9, rand_vec());
    for (int i = 0; i < 40; i++) begin
      out_ready = ~out_ready;
      tick();
    end
    out_ready = 1'b1;
    wait_drain("t2_drain", 40);

    // 3: five back-to-back pushes into a stalled FIFO, then clear overflow and drain.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_vec(ADDR_W'(10 + i), rand_vec());
    tick();
    check("t3_full", full, 1'b1);
    check("t3_ovf", overflow, 1'b1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("t3_ovf_clr", overflow, 1'b0);
    out_ready = 1'b1;
    wait_drain("t3_drain", 100);

    // 4: push coincident with the head's last-byte transfer while full.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_vec(ADDR_W'(20 + i), rand_vec());
    out_ready = 1'b1;
    wait_for_last(40, seen);
    if (seen) begin
      push_vec(5'd31, rand_vec());
      check("t4_count", count, DEPTH);
      check("t4_ovf", overflow, 1'b0);
    end
    wait_drain("t4_drain", 120);

    // 5: reset in the middle of a vector with two more queued.
    for (int i = 0; i < 3; i++) push_vec(ADDR_W'(i + 1), rand_vec());
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      if (out_valid && out_idx == IDX_W'(7)) reached = 1'b1;
      else tick();
    end
    check("t5_reach_idx7", reached, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_outputs("t5_reset");
    tick();
    tick();
    reset = 1'b1;
    tick();
    push_vec(5'd17, rand_vec());
    check("t5_restart_idx", out_idx, '0);
    wait_drain("t5_drain", 40);

    // 6: ten vectors with random gaps to wrap the pointers.
    for (int i = 0; i < 10; i++) begin
      push_vec(ADDR_W'(i), rand_vec());
      for (int g = 0; g < int'($urandom_range(0, 6)); g++) tick();
    end
    wait_drain("t6_drain", 300);

    // Random traffic: writes, back-pressure and overflow clears.
    for (int i = 0; i < 1500; i++) begin
      conv_write = ($urandom_range(0, 3) == 0);
      conv_addr  = ADDR_W'($urandom);
      conv_v     = rand_vec();
      out_ready  = ($urandom_range(0, 2) != 0);
      clear_ovf  = ($urandom_range(0, 15) == 0);
      tick();
    end
    conv_write = 1'b0;
    clear_ovf  = 1'b0;
    out_ready  = 1'b1;
    wait_drain("rand_drain", 200);

    check("scoreboard_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
